rr_ram_arbiter: RTL

Round-robin arbiter that shares one single-port synchronous RAM among NCORES requesters. Each core gets one complete transaction per grant: one read or one write. Per-core request/grant/done handshakes replace hold-the-bus ownership, and the RAM read latency is a parameter. It sits between the core array and the shared data RAM, in the same position as the existing byte-wide memory controller.

---
 rtl/rr_ram_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rr_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores.
// One complete read or write per grant, signalled back with a one-cycle done pulse.
module rr_ram_arbiter #(
  parameter int NCORES = 8,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    done,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren,
  input  logic [DW-1:0]        ram_q
);

  localparam int IW = $clog2(NCORES);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic              wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCORES-1:0] gnt_q, gnt_d;
  logic [NCORES-1:0] done_q, done_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [DW-1:0]     rdin_q, rdin_d;
  logic              rwren_q, rwren_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [IW-1:0]     pick;

  // First requester after the last granted core, wrapping modulo NCORES.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    found = 1'b0;
    pick  = ptr_q;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NCORES; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NCORES) j -= NCORES;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    rdin_d  = rdin_q;
    rwren_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_ACCESS;
          ptr_d       = pick;
          win_d       = pick;
          wr_d        = we[pick];
          raddr_d     = addr[pick*AW +: AW];
          rdin_d      = wdata[pick*DW +: DW];
          rwren_d     = we[pick];
          gnt_d[pick] = 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = CW'(RD_LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d       = S_RESP;
          done_d[win_q] = 1'b1;
          if (!wr_q) rdata_d = ram_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NCORES - 1);
      win_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      rdin_q  <= '0;
      rwren_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      rdin_q  <= rdin_d;
      rwren_q <= rwren_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_addr = raddr_q;
  assign ram_din  = rdin_q;
  assign ram_wren = rwren_q;

endmodule
